// File: rtl/ioctl_upload.sv
// SPI-slave reader that streams machine RAM back to the host (tape/RKA save).
// Optional CRC-16/CCITT trailer after the data bytes: define IOCTL_UPLOAD_CRC_EN.
module ioctl_upload #(
    parameter logic [7:0]  CMD_BEGIN = 8'h60,
    parameter logic [24:0] BASE      = 25'h0,
    parameter int          RD_LAT    = 4,
    parameter logic [7:0]  PAD       = 8'hFF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        spi_sck,
    input  logic        spi_ss,
    input  logic        spi_di,
    output logic        spi_do,
    output logic        spi_do_oe,
    output logic        uploading,
    output logic [4:0]  index,
    input  logic [24:0] size,
    output logic        rd,
    output logic [24:0] a,
    input  logic [7:0]  d,
    output logic        underrun,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_IGNORE, S_INDEX, S_STREAM} state_t;
    state_t state, state_nx;

    logic [2:0]  sck_sr, ss_sr;
    logic [1:0]  di_sr;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_byte, tx_buf, tx_shift;
    logic [24:0] sent, sent_nx;
    logic [RD_LAT-1:0] lat_sr;
    logic        ready, sck_rise, sck_fall, ss_hi, ss_fall, di_s;
    logic        byte_done, cmd_hit, idx_done, load, more_data;
    logic [7:0]  tail_nx, tail_first;

    assign sck_rise  = sck_sr[1] & ~sck_sr[2];
    assign sck_fall  = ~sck_sr[1] & sck_sr[2];
    assign ss_hi     = ss_sr[1];
    assign ss_fall   = ss_sr[2] & ~ss_sr[1];
    assign di_s      = di_sr[1];
    assign rx_byte   = {rx_shift, di_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && !ss_hi;
    assign cmd_hit   = (state == S_CMD) && byte_done && (rx_byte == CMD_BEGIN);
    assign idx_done  = (state == S_INDEX) && byte_done;
    // Transmit side turns over on the first falling edge of each byte, so
    // byte 0 can be fetched after the index byte and still meet the first bit.
    assign load      = (state == S_STREAM) && sck_fall && (bit_cnt == 3'd0) && !ss_hi;
    assign more_data = (sent < size);
    assign sent_nx   = more_data ? sent + 25'd1 : sent;

    assign uploading = (state == S_STREAM);
    assign spi_do_oe = (state == S_STREAM) && !ss_hi;
    assign state_dbg = state;

`ifdef IOCTL_UPLOAD_CRC_EN
    logic [15:0] crc, crc_upd, crc_cur;
    logic [1:0]  crc_stage;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ b[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    assign crc_upd    = crc16_byte(crc, tx_buf);
    assign crc_cur    = more_data ? crc_upd : crc;
    assign tail_first = 8'hFF;

    always_comb begin
        tail_nx = PAD;
        case (crc_stage)
            2'd0:    tail_nx = crc_cur[15:8];
            2'd1:    tail_nx = crc[7:0];
            default: tail_nx = PAD;
        endcase
    end
`else
    assign tail_nx    = PAD;
    assign tail_first = PAD;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sck_sr   <= '0;
            ss_sr    <= '1;
            di_sr    <= '0;
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else begin
            sck_sr <= {sck_sr[1:0], spi_sck};
            ss_sr  <= {ss_sr[1:0], spi_ss};
            di_sr  <= {di_sr[0], spi_di};
            if (ss_hi) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= {rx_shift[5:0], di_s};
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (ss_hi) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (ss_fall) state_nx = S_CMD;
                S_CMD:    if (byte_done) state_nx = (rx_byte == CMD_BEGIN) ? S_INDEX : S_IGNORE;
                S_IGNORE: state_nx = S_IGNORE;
                S_INDEX:  if (byte_done) state_nx = S_STREAM;
                S_STREAM: state_nx = S_STREAM;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    // RAM side: rd is a one-cycle strobe with a held; d is taken exactly
    // RD_LAT cycles later with no back-pressure. Late data after a deselect is dropped.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            index    <= '0;
            rd       <= 1'b0;
            a        <= BASE;
            underrun <= 1'b0;
            sent     <= '0;
            ready    <= 1'b0;
            tx_buf   <= PAD;
            tx_shift <= '0;
            spi_do   <= 1'b0;
            lat_sr   <= '0;
`ifdef IOCTL_UPLOAD_CRC_EN
            crc       <= 16'hFFFF;
            crc_stage <= 2'd0;
`endif
        end else begin
            rd     <= 1'b0;
            lat_sr <= RD_LAT'({lat_sr, rd});
            if (cmd_hit) begin
                underrun <= 1'b0;
`ifdef IOCTL_UPLOAD_CRC_EN
                crc <= 16'hFFFF;
`endif
            end
            if (idx_done) begin
                index <= rx_byte[4:0];
                a     <= BASE;
                sent  <= '0;
                if (size != '0) begin
                    rd    <= 1'b1;
                    ready <= 1'b0;
                end else begin
                    tx_buf <= tail_first;
                    ready  <= 1'b1;
                end
`ifdef IOCTL_UPLOAD_CRC_EN
                crc_stage <= (size != '0) ? 2'd0 : 2'd1;
`endif
            end else if ((state == S_STREAM) && !ss_hi) begin
                if (lat_sr[RD_LAT-1]) begin
                    tx_buf <= d;
                    ready  <= 1'b1;
                end
                if (load) begin
                    spi_do   <= tx_buf[7];
                    tx_shift <= {tx_buf[6:0], 1'b0};
                    a        <= a + 25'd1;
                    ready    <= 1'b0;
                    sent     <= sent_nx;
                    if (!ready) underrun <= 1'b1;
`ifdef IOCTL_UPLOAD_CRC_EN
                    if (more_data) crc <= crc_upd;
`endif
                    if (sent_nx < size) begin
                        rd <= 1'b1;
                    end else begin
                        tx_buf <= tail_nx;
                        ready  <= 1'b1;
`ifdef IOCTL_UPLOAD_CRC_EN
                        crc_stage <= (crc_stage == 2'd2) ? 2'd2 : crc_stage + 2'd1;
`endif
                    end
                end else if (sck_fall) begin
                    spi_do   <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end else begin
                spi_do <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ioctl_upload.md
Name: ioctl_upload

Overview:
- SPI-slave reader that streams machine RAM back to the host (tape/RKA save).
- It is the other direction of the data_io download path: data_io writes host bytes into sram; this block reads sram bytes out to the host.
- Sits beside data_io on the same SPI_SCK/SPI_DI wires, with its own slave select and a shared SPI_DO.
- The top-level RAM mux gives it priority over the CPU while `uploading` is high, as it does for ioctl_download.

Parameters:
- CMD_BEGIN, 8'h60, command byte that opens an upload transaction.
- BASE, 25'h0, RAM address of the first uploaded byte.
- RD_LAT, 4, clk_sys cycles from the rd pulse until d is valid.
- PAD, 8'hFF, byte shifted out once `size` bytes have been sent.

Ports:
- clk_sys  in  1  system clock, 48 MHz.
- reset_n  in  1  asynchronous active-low reset.
- spi_sck  in  1  SPI clock, asynchronous to clk_sys.
- spi_ss  in  1  slave select, active low, asynchronous.
- spi_di  in  1  host-to-device serial data.
- spi_do  out  1  device-to-host serial data.
- spi_do_oe  out  1  drive enable for the shared SPI_DO line.
- uploading  out  1  transaction active; top-level RAM mux selects this block.
- index  out  5  file index received after CMD_BEGIN.
- size  in  25  number of bytes to upload.
- rd  out  1  one-cycle RAM read strobe.
- a  out  25  RAM address.
- d  in  8  RAM read data.
- underrun  out  1  sticky: a byte boundary arrived before the prefetch completed.

Behaviour:
- Reset values: spi_do=0, spi_do_oe=0, uploading=0, index=0, rd=0, a=BASE, underrun=0, state=IDLE.
- Synchronisation: spi_sck, spi_ss and spi_di each pass through 2 flops. sck edges are detected from the synchronised value.
- SPI format: mode 0, MSB first. di is sampled on the sck rising edge; do changes on the sck falling edge.
- Bit count: a 3-bit counter is cleared whenever ss is high. Every 8th rising edge completes a byte.
- Deselect: ss high forces state=IDLE, spi_do_oe=0 and uploading=0 within 3 clk_sys cycles, from any state. An rd already in flight completes, but its data is discarded. index holds its last value.
- spi_do_oe = (state==STREAM) && ss low.
- State machine:
  - IDLE→CMD on the ss falling edge.
  - CMD: if the received byte == CMD_BEGIN → INDEX; otherwise → IGNORE.
  - IGNORE: stays there until ss goes high. Produces no output and no rd.
  - INDEX: on the byte boundary, index = byte[4:0], uploading=1, a=BASE, sent=0, tx_shift preloaded, then → STREAM. The first rd (addr BASE) is issued in the same cycle.
- Prefetch in STREAM:
  - After each rd, d is latched into tx_buf exactly RD_LAT cycles later and a `ready` flag is set.
  - At each byte boundary: tx_shift=tx_buf, sent+=1, a+=1, ready=0, and the next rd is issued on the following cycle.
- Size limit: when sent >= size, no rd is issued and tx_buf=PAD. With size=0 the stream consists only of PAD bytes.
- Underrun: a byte boundary with ready=0 sets underrun (sticky until the next CMD_BEGIN). The stale tx_buf is shifted and the address still advances.
- Required sck rate: sck period >= 2*(RD_LAT+6) clk_sys cycles, i.e. <= 2.4 MHz at RD_LAT=4. At or below this rate, underrun never sets.
- First data bit: the MSB of byte 0 is driven on the first sck falling edge after the index byte completes.
- Widths and wrap:
  - a is 25 bits and wraps modulo 2^25 with no flag.
  - sent is a 25-bit counter and saturates at size.
- Reset mid-transaction: immediate return to reset values; the host must reselect and resend CMD_BEGIN.
- Simultaneous ss rise and byte boundary: deselect wins. No address increment, no rd.

Optional Feature:
- Macro: IOCTL_UPLOAD_CRC_EN.
- Defined:
  - A CRC-16/CCITT (poly 0x1021, init 0xFFFF, MSB first) is computed over the `size` data bytes as they are loaded into tx_shift.
  - The two bytes after the data are the CRC, high byte then low byte. PAD follows.
  - The CRC resets on CMD_BEGIN.
- Undefined: the byte immediately after the data is PAD; no CRC logic is present.

Test Plan:
- Reset: assert reset_n=0 mid-stream → all outputs return to reset values within 1 cycle; rd never pulses while reset is asserted.
- Basic read: RAM[0..3]=11,22,33,44, size=4, send 60,03, clock 6 bytes → index=3; host receives 11,22,33,44,FF,FF; exactly 4 rd pulses with a=0..3.
- Bad command: send 5A then 24 clocks → do_oe stays 0, uploading=0, no rd.
- Deselect mid-byte: raise ss after 5 bits of byte 1 → uploading=0 within 3 cycles; reselect with 60,00 → stream restarts at BASE.
- Underrun: sck at clk_sys/8 with RD_LAT=4 → underrun=1 after the first data byte. At clk_sys/20 → underrun stays 0 for 256 bytes.
- CRC (IOCTL_UPLOAD_CRC_EN): size=9, data "123456789" → bytes after the data are 29, B1, then FF.
